// File: rtl/dram_feeder_pkg.sv
// Shared accelerator definitions: feeder state encoding and default data width.
package dram_feeder_pkg;

  localparam int DATA_SIZE_DEF = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    DRAIN    = 3'd2,
    WAIT_OUT = 3'd3,
    FINISH   = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/dram_feeder_fifo.sv
// Prefetch queue: shift-register FIFO whose head is always entry 0, so the
// head word comes straight from a flop. Push and pop may share a cycle.
module feeder_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  data [DEPTH];
  logic          do_pop;
  logic          do_push;
  logic [CW-1:0] wr_idx;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  // With a simultaneous pop everything shifts down one slot first.
  assign wr_idx  = do_pop ? count - CW'(1) : count;
  assign head    = data[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) data[i] <= data[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (CW'(i) == wr_idx)) data[i] <= din;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dram_feeder.sv
// Streams a block of DRAM words into the accelerator through a prefetch FIFO
// and writes the accelerator's ofmap words into the result buffer.
module dram_feeder
  import dram_feeder_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int MEM_AW     = 16,
  parameter int RES_AW     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MEM_AW-1:0]    base_addr,
  input  logic [11:0]          load_len,
  output logic                 mem_req,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 acc_ready,
  output logic [DATA_SIZE-1:0] acc_data,
  input  logic                 acc_valid,
  input  logic [DATA_SIZE-1:0] acc_ofmap,
  input  logic                 acc_done,
  output logic                 res_we,
  output logic [RES_AW-1:0]    res_addr,
  output logic [DATA_SIZE-1:0] res_wdata,
  output logic                 busy,
  output logic                 finished,
  output logic                 err,
  output feeder_state_e        dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshakes: mem_req/mem_addr stay stable until a cycle with mem_gnt high,
  // and that cycle transfers the request; mem_rvalid returns arrive in order
  // with no backpressure. acc_ready has no counterpart: every cycle it is
  // high, acc_data is consumed. acc_valid likewise transfers one word per cycle.
  feeder_state_e        state;
  logic [MEM_AW-1:0]    base_q;
  logic [11:0]          len_q;
  logic [11:0]          requested;
  logic [11:0]          sent;
  logic [CW-1:0]        outstanding;
  logic [RES_AW-1:0]    res_cnt;
  logic                 err_q;
  logic                 busy_q;
  logic                 fin_q;

  logic                 streaming;
  logic                 capturing;
  logic                 credit_ok;
  logic                 granted;
  logic                 ret_ok;
  logic                 stray;
  logic                 fifo_clr;
  logic [DATA_SIZE-1:0] fifo_head;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;

  assign streaming = (state == LOAD) || (state == DRAIN);
  assign capturing = streaming || (state == WAIT_OUT);
  // Credit counts words in the FIFO plus words still in flight from DRAM.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(FIFO_DEPTH);
  assign mem_req   = (state == LOAD) && (requested < len_q) && credit_ok;
  assign mem_addr  = mem_req ? base_q + MEM_AW'(requested) : '0;
  assign granted   = mem_req && mem_gnt;
  assign ret_ok    = mem_rvalid && (outstanding != '0);
  assign stray     = mem_rvalid && (outstanding == '0);

  assign acc_ready = streaming && !fifo_empty;
  assign acc_data  = acc_ready ? fifo_head : '0;
  assign res_we    = capturing && acc_valid;
  assign res_addr  = res_we ? res_cnt : '0;
  assign res_wdata = res_we ? acc_ofmap : '0;

  assign fifo_clr  = (streaming && acc_done) || ((state == IDLE) && start);

  assign busy      = busy_q;
  assign finished  = fin_q;
  assign err       = err_q;
  assign dbg_state = state;

  feeder_fifo #(
    .W     (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (ret_ok),
    .din   (mem_rdata),
    .pop   (acc_ready),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      requested   <= '0;
      sent        <= '0;
      outstanding <= '0;
      res_cnt     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      if (granted && !ret_ok)      outstanding <= outstanding + CW'(1);
      else if (!granted && ret_ok) outstanding <= outstanding - CW'(1);
      if (granted)   requested <= requested + 12'd1;
      if (acc_ready) sent      <= sent + 12'd1;
      if (res_we) begin
        res_cnt <= res_cnt + RES_AW'(1);
        if (&res_cnt) err_q <= 1'b1;
      end
      if (stray) err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            len_q       <= load_len;
            requested   <= '0;
            sent        <= '0;
            outstanding <= '0;
            res_cnt     <= '0;
            err_q       <= stray;
            busy_q      <= 1'b1;
            state       <= (load_len == 12'd0) ? WAIT_OUT : LOAD;
          end
        end
        LOAD, DRAIN: begin
          if (acc_done) begin
            // Early done: abandon queued and in-flight words.
            err_q       <= 1'b1;
            outstanding <= '0;
            fin_q       <= 1'b1;
            state       <= FINISH;
          end else if ((state == LOAD) && (requested == len_q)) begin
            state <= DRAIN;
          end else if ((state == DRAIN) && (sent == len_q)) begin
            state <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (acc_done) begin
            fin_q <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_feeder.sv
// Directed bench for dram_feeder: a DRAM responder model, an acc/result
// scoreboard monitor, and directed jobs with hand-derived expectations.
module tb_dram_feeder;
  import dram_feeder_pkg::*;

  logic          clk;
  logic          rst;
  logic          start;
  logic [15:0]   base_addr;
  logic [11:0]   load_len;
  logic          mem_req;
  logic [15:0]   mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          acc_ready;
  logic [31:0]   acc_data;
  logic          acc_valid;
  logic [31:0]   acc_ofmap;
  logic          acc_done;
  logic          res_we;
  logic [6:0]    res_addr;
  logic [31:0]   res_wdata;
  logic          busy;
  logic          finished;
  logic          err;
  feeder_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [38:0] exp_res_q[$];

  int lat        = 1;
  int gnt_budget = -1;
  int cyc        = 0;
  int max_pend   = 0;
  int due_q[$];
  logic [31:0] dat_q[$];

  int run_cur = 0;
  int run_max = 0;
  int fin_cnt = 0;
  logic [31:0] mon_e;
  logic [38:0] mon_r;

  dram_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .load_len   (load_len),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_valid  (acc_valid),
    .acc_ofmap  (acc_ofmap),
    .acc_done   (acc_done),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_wdata  (res_wdata),
    .busy       (busy),
    .finished   (finished),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // DRAM model: grants every request, returns data == address after lat cycles.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = dat_q.pop_front();
        void'(due_q.pop_front());
      end
      mem_gnt = 1'b0;
      if (mem_req && gnt_budget != 0) begin
        mem_gnt = 1'b1;
        due_q.push_back(cyc + lat);
        dat_q.push_back(32'(mem_addr));
        if (gnt_budget > 0) gnt_budget--;
      end
      if (due_q.size() > max_pend) max_pend = due_q.size();
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (acc_ready) begin
        run_cur++;
        if (run_cur > run_max) run_max = run_cur;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL acc_word: got %0h want none", acc_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (acc_data !== mon_e) begin
            bad++;
            $display("FAIL acc_word: got %0h want %0h", acc_data, mon_e);
          end
        end
      end else begin
        run_cur = 0;
      end
      if (res_we) begin
        total++;
        if (exp_res_q.size() == 0) begin
          bad++;
          $display("FAIL res_write: got %0h/%0h want none", res_addr, res_wdata);
        end else begin
          mon_r = exp_res_q.pop_front();
          if ({res_addr, res_wdata} !== mon_r) begin
            bad++;
            $display("FAIL res_write: got %0h/%0h want %0h/%0h",
                     res_addr, res_wdata, mon_r[38:32], mon_r[31:0]);
          end
        end
      end
      if (finished) fin_cnt++;
    end
  end

  task automatic pulse_start(input logic [15:0] base, input logic [11:0] len);
    @(negedge clk);
    base_addr = base;
    load_len  = len;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] base, input logic [11:0] len);
    int f0;
    f0 = fin_cnt;
    for (int i = 0; i < int'(len); i++) exp_q.push_back(32'(base + 16'(i)));
    pulse_start(base, len);
    for (int k = 0; k < 1000; k++) begin
      if (dbg_state == WAIT_OUT) break;
      @(negedge clk);
    end
    check("reach_wait_out", 64'(dbg_state), 64'(WAIT_OUT));
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    #1;
    check("job_fifo_empty", 64'(exp_q.size()), 64'd0);
    check("job_finished", 64'(finished), 64'd1);
    @(negedge clk);
    #1;
    check("job_idle", 64'(busy), 64'd0);
    check("job_err", 64'(err), 64'd0);
    check("job_fin_count", 64'(fin_cnt - f0), 64'd1);
  endtask

  task automatic results_job(input int n, input logic exp_err);
    int f0;
    logic [31:0] d;
    f0 = fin_cnt;
    pulse_start(16'h0000, 12'd0);
    for (int i = 0; i < n; i++) begin
      if (i == 127) begin
        #1;
        check("err_before_wrap", 64'(err), 64'd0);
      end
      if (i == 128) begin
        #1;
        check("err_after_wrap", 64'(err), 64'd1);
      end
      d = 32'hC000_0000 + 32'(i * 7);
      acc_valid = 1'b1;
      acc_ofmap = d;
      acc_done  = (i == n - 1);
      exp_res_q.push_back({7'(i), d});
      @(negedge clk);
    end
    acc_valid = 1'b0;
    acc_done  = 1'b0;
    acc_ofmap = '0;
    #1;
    check("res_finished", 64'(finished), 64'd1);
    check("res_q_empty", 64'(exp_res_q.size()), 64'd0);
    @(negedge clk);
    #1;
    check("res_idle", 64'(dbg_state), 64'(IDLE));
    check("res_err", 64'(err), 64'(exp_err));
    check("res_fin_count", 64'(fin_cnt - f0), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_acc_ready"}, 64'(acc_ready), 64'd0);
    check({tag, "_acc_data"}, 64'(acc_data), 64'd0);
    check({tag, "_res_we"}, 64'(res_we), 64'd0);
    check({tag, "_res_addr"}, 64'(res_addr), 64'd0);
    check({tag, "_res_wdata"}, 64'(res_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_finished"}, 64'(finished), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    load_len  = '0;
    acc_valid = 1'b0;
    acc_ofmap = '0;
    acc_done  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 16 words at latency 1: one word per cycle, 0x0100..0x010F
    lat     = 1;
    run_max = 0;
    run_job(16'h0100, 12'd16);
    check("lat1_consecutive_run", 64'(run_max), 64'd16);

    // Latency 5: in-flight requests bounded by the FIFO depth
    lat      = 5;
    max_pend = 0;
    run_job(16'h2000, 12'd12);
    check("lat5_max_outstanding_le4", 64'(max_pend <= 4), 64'd1);

    // load_len 0: 8 result writes at 0..7
    results_job(8, 1'b0);

    // Early acc_done after 3 of 8 words
    lat        = 1;
    gnt_budget = 3;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h0300 + 32'(i));
    pulse_start(16'h0300, 12'd8);
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && due_q.size() == 0) break;
      @(negedge clk);
    end
    check("abort_three_sent", 64'(exp_q.size()), 64'd0);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    #1;
    check("abort_state_finish", 64'(dbg_state), 64'(FINISH));
    check("abort_finished", 64'(finished), 64'd1);
    check("abort_err", 64'(err), 64'd1);
    check("abort_acc_ready", 64'(acc_ready), 64'd0);
    @(negedge clk);
    #1;
    check("abort_state_idle", 64'(dbg_state), 64'(IDLE));
    check("abort_busy", 64'(busy), 64'd0);
    gnt_budget = -1;

    // 130 result words: address wraps 127 -> 0 and err is raised
    results_job(130, 1'b1);

    // Reset mid-LOAD with two reads in flight
    lat = 5;
    pulse_start(16'h0400, 12'd8);
    for (int k = 0; k < 50; k++) begin
      #1;
      if (due_q.size() >= 2) break;
      @(negedge clk);
    end
    check("pre_reset_in_flight", 64'(due_q.size()), 64'd2);
    check("pre_reset_state", 64'(dbg_state), 64'(LOAD));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (due_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    check("stray_return_err", 64'(err), 64'd1);
    check("stray_no_acc", 64'(acc_ready), 64'd0);
    lat = 1;
    run_job(16'h0500, 12'd6);

    check("final_acc_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_res_q_empty", 64'(exp_res_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_feeder.md
DRAM_FEEDER -- requirements
Module: dram_feeder

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, the width of a data word on every data port.
REQ-002 SHALL have parameter MEM_AW, default 16, the width of the DRAM word address.
REQ-003 SHALL have parameter RES_AW, default 7, the width of the result-buffer address.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two), the number of prefetch FIFO entries.
REQ-005 SHALL have these ports:
- clk  in  1  sole clock; one clock domain, all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a job.
- base_addr  in  MEM_AW  first DRAM word address of the job.
- load_len  in  12  number of words to stream into the accelerator.
- mem_req  out  1  DRAM read request.
- mem_addr  out  MEM_AW  DRAM read address.
- mem_gnt  in  1  DRAM request accepted.
- mem_rvalid  in  1  DRAM read data valid; returns are in order.
- mem_rdata  in  DATA_SIZE  DRAM read data.
- acc_ready  out  1  drives the accelerator ready input; high means acc_data is consumed this cycle.
- acc_data  out  DATA_SIZE  drives the accelerator data_in.
- acc_valid  in  1  accelerator ofmap valid.
- acc_ofmap  in  DATA_SIZE  accelerator ofmap.
- acc_done  in  1  accelerator done.
- res_we  out  1  result-buffer write enable.
- res_addr  out  RES_AW  result-buffer write address.
- res_wdata  out  DATA_SIZE  result-buffer write data.
- busy  out  1  high while in any state other than IDLE.
- finished  out  1  one-cycle pulse at the end of a job.
- err  out  1  sticky error flag; cleared by start.

Function
REQ-006 SHALL implement the states IDLE, LOAD, DRAIN, WAIT_OUT and FINISH.
REQ-007 SHALL, in IDLE on start, latch base_addr and load_len, clear the counters and err, and move to LOAD, or to WAIT_OUT if load_len==0.
REQ-008 SHALL ignore start while busy.
REQ-009 SHALL, in LOAD, assert mem_req whenever requested<load_len and (FIFO count + outstanding)<FIFO_DEPTH, with mem_addr=base_addr+requested.
REQ-010 SHALL hold mem_req and mem_addr stable until mem_gnt, and SHALL increment requested and outstanding on each grant.
REQ-011 SHALL push mem_rdata into the FIFO on mem_rvalid and decrement outstanding; a grant and an rvalid in the same cycle SHALL leave outstanding unchanged.
REQ-012 SHALL set err and drop the word if mem_rvalid arrives with outstanding==0.
REQ-013 SHALL drive acc_ready=1 when the FIFO is non-empty in LOAD or DRAIN, with acc_data equal to the FIFO head; each acc_ready cycle pops exactly one word.
REQ-014 SHALL allow a push and a pop in the same cycle, leaving the FIFO count unchanged.
REQ-015 SHALL move from LOAD to DRAIN when requested==load_len, and from DRAIN to WAIT_OUT when sent==load_len.
REQ-016 SHALL stream a word to the accelerator no earlier than 1 cycle after its mem_rvalid, and SHALL sustain one word per cycle when DRAM returns one word per cycle.
REQ-017 SHALL, in LOAD, DRAIN and WAIT_OUT, on each acc_valid cycle, drive res_we=1, res_wdata=acc_ofmap and res_addr=result count in the same cycle, then increment the result count.
REQ-018 SHALL wrap the result count modulo 2^RES_AW and set err on the wrap.
REQ-019 SHALL ignore acc_valid in IDLE and FINISH.
REQ-020 SHALL, on acc_done in WAIT_OUT, still capture that cycle's acc_valid word, then enter FINISH.
REQ-021 SHALL, on acc_done in LOAD or DRAIN, set err and enter FINISH, discarding the FIFO contents and any outstanding returns.
REQ-022 SHALL pulse finished for one cycle in FINISH and return to IDLE the next cycle.

Reset
REQ-023 SHALL, on rst low and regardless of clk, force state IDLE; clear the FIFO, all counters and err; and drive mem_req, acc_ready, res_we, busy and finished to 0 and all address and data outputs to 0.
REQ-024 SHALL abandon any job in progress when reset is asserted; a DRAM return arriving after reset release SHALL set err.

Structure
REQ-025 SHALL take the state enum and the DATA_SIZE default from the shared accelerator package.
REQ-026 SHALL implement the prefetch queue as one sub-module, feeder_fifo (synchronous, registered head, count output).

Verification
REQ-027 SHALL cover: load_len=16, base 0x0100, DRAM latency 1 -> 16 consecutive acc_ready cycles carrying words 0x0100..0x010F in order.
REQ-028 SHALL cover: DRAM latency 5, gnt every cycle -> outstanding never exceeds 4 and no word is dropped or reordered.
REQ-029 SHALL cover: load_len=0, then acc_valid×8 and acc_done -> res_addr 0..7 written, one finished pulse, err=0.
REQ-030 SHALL cover: acc_done after 3 of 8 words -> err=1, FINISH then IDLE, acc_ready low.
REQ-031 SHALL cover: 130 acc_valid words with RES_AW=7 -> res_addr wraps 127→0 and err=1.
REQ-032 SHALL cover: rst low mid-LOAD with 2 words outstanding -> all outputs 0 immediately, and a later start runs a clean job.
